// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU and its sharing arbiter: datapath width,
//   opcode encoding, requester port indices and the exec-stage state type.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;

    localparam int PORT_EXEC = 0;   // execute path
    localparam int PORT_HELP = 1;   // address/branch helper
    localparam int NUM_PORTS = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } exec_state_t;

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   Purely combinational integer ALU.
//   Ports:
//     a, b    in   XLEN  operands
//     op      in   4     opcode (alu_pkg encoding)
//     result  out  XLEN  result; 0 for opcodes outside the supported set
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arb2.sv
// -----------------------------------------------------------------------------
// alu_rr_arb2
//   Two-way arbiter with round-robin or fixed-priority tie breaking.
//   Ports:
//     clk, rst  in   1  clock, asynchronous active-high reset
//     en        in   1  grants are suppressed while low
//     elig      in   2  per-port eligibility
//     grant     out  2  one-hot (or zero) grant
// -----------------------------------------------------------------------------
module alu_rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    // Index of the most recently granted port; resets to 1 so port 0 wins
    // the first tie.
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (FIXED_PRIO || last_grant) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one ALU between the execute path (port 0) and the address/branch
//   helper (port 1). An accepted request is latched into a one-cycle exec
//   stage, and its result lands in the owner's response register on the
//   following edge. Each port has at most one operation outstanding.
//   Ports (index p in {0,1}):
//     clk, rst          in   1      clock, asynchronous active-high reset
//     req_valid_i[p]    in   1      request present
//     req_ready_o[p]    out  1      request accepted when valid && ready
//     req_a_i/b_i[p]    in   XLEN   operands
//     req_op_i[p]       in   4      opcode
//     req_tag_i[p]      in   TAG_W  tag, echoed on the response
//     rsp_valid_o[p]    out  1      response register holds a result
//     rsp_ready_i[p]    in   1      response consumed when valid && ready
//     rsp_result_o[p]   out  XLEN   result
//     rsp_zero_o[p]     out  1      result == 0
//     rsp_illegal_o[p]  out  1      opcode outside the supported set
//     rsp_tag_o[p]      out  TAG_W  tag of the operation
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [XLEN-1:0]   req_a_i      [NUM_PORTS],
    input  logic [XLEN-1:0]   req_b_i      [NUM_PORTS],
    input  logic [3:0]        req_op_i     [NUM_PORTS],
    input  logic [TAG_W-1:0]  req_tag_i    [NUM_PORTS],
    output logic [1:0]        rsp_valid_o,
    input  logic [1:0]        rsp_ready_i,
    output logic [XLEN-1:0]   rsp_result_o [NUM_PORTS],
    output logic [1:0]        rsp_zero_o,
    output logic [1:0]        rsp_illegal_o,
    output logic [TAG_W-1:0]  rsp_tag_o    [NUM_PORTS]
);

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic             gnt_any;
    logic             gnt_idx;

    exec_state_t      state_p1;
    logic             owner_p1;
    logic [XLEN-1:0]  a_p1;
    logic [XLEN-1:0]  b_p1;
    logic [3:0]       op_p1;
    logic [TAG_W-1:0] tag_p1;

    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  res_p1;
    logic             legal_p1;

    // A port with a result waiting or an op in exec may not issue again.
    always_comb begin
        eligible = 2'b00;
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = req_valid_i[p] && !rsp_valid_o[p] &&
                          !((state_p1 == ST_EXEC) && (owner_p1 == 1'(p)));
        end
    end

    alu_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (!rst),
        .elig  (eligible),
        .grant (grant)
    );

    assign req_ready_o = grant;
    assign gnt_any     = |grant;
    assign gnt_idx     = grant[1];

    // ---- stage p0 -> p1: latch the accepted request into exec ----
    always_ff @(posedge clk) begin
        if (gnt_any) begin
            a_p1   <= req_a_i[gnt_idx];
            b_p1   <= req_b_i[gnt_idx];
            op_p1  <= req_op_i[gnt_idx];
            tag_p1 <= req_tag_i[gnt_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= ST_IDLE;
            owner_p1 <= 1'b0;
        end else begin
            case (state_p1)
                ST_IDLE: begin
                    if (gnt_any) begin
                        state_p1 <= ST_EXEC;
                        owner_p1 <= gnt_idx;
                    end
                end
                ST_EXEC: begin
                    // Exec always retires after one cycle; stay only for a
                    // back-to-back grant to the other port.
                    if (gnt_any) begin
                        owner_p1 <= gnt_idx;
                    end else begin
                        state_p1 <= ST_IDLE;
                    end
                end
                default: state_p1 <= ST_IDLE;
            endcase
        end
    end

    alu u_alu (
        .a      (a_p1),
        .b      (b_p1),
        .op     (op_p1),
        .result (alu_res)
    );

    assign legal_p1 = op_legal(op_p1);
    assign res_p1   = legal_p1 ? alu_res : '0;

    // ---- stage p1 -> p2: retire exec into the owner's response register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_o   <= 2'b00;
            rsp_zero_o    <= 2'b00;
            rsp_illegal_o <= 2'b00;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rsp_result_o[p] <= '0;
                rsp_tag_o[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                // The owner's response register is known empty here, so a
                // retire never collides with a drain on the same port.
                if ((state_p1 == ST_EXEC) && (owner_p1 == 1'(p))) begin
                    rsp_valid_o[p]   <= 1'b1;
                    rsp_result_o[p]  <= res_p1;
                    rsp_zero_o[p]    <= (res_p1 == '0);
                    rsp_illegal_o[p] <= !legal_p1;
                    rsp_tag_o[p]     <= tag_p1;
                end else if (rsp_ready_i[p]) begin
                    rsp_valid_o[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter (round-robin instance plus a
//   fixed-priority instance sharing the same inputs).
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_illegal;
    logic [31:0]      req_a [2];
    logic [31:0]      req_b [2];
    logic [3:0]       req_op [2];
    logic [TAG_W-1:0] req_tag [2];
    logic [31:0]      rsp_result [2];
    logic [TAG_W-1:0] rsp_tag [2];

    logic [1:0]       fp_req_ready, fp_rsp_valid, fp_rsp_zero, fp_rsp_illegal;
    logic [31:0]      fp_rsp_result [2];
    logic [TAG_W-1:0] fp_rsp_tag [2];

    alu_share_arbiter #(.TAG_W(TAG_W), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op), .req_tag_i(req_tag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
        .rsp_illegal_o(rsp_illegal), .rsp_tag_o(rsp_tag)
    );

    alu_share_arbiter #(.TAG_W(TAG_W), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(fp_req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op), .req_tag_i(req_tag),
        .rsp_valid_o(fp_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(fp_rsp_result), .rsp_zero_o(fp_rsp_zero),
        .rsp_illegal_o(fp_rsp_illegal), .rsp_tag_o(fp_rsp_tag)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU: what each opcode means arithmetically.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill);
        ill = 1'b0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    // ---------------- transaction-level reference model ----------------
    // Each port has at most one outstanding op; a port may issue only when
    // it has none. An op accepted in cycle c is visible as a response from
    // cycle c+2 until it is consumed.
    bit          busy [2];
    int          acc_cyc [2];
    logic [31:0] exp_res [2];
    logic        exp_ill [2];
    logic [3:0]  exp_tag [2];
    int          last_g = 1;
    int          cyc = 0;

    always @(negedge clk) begin
        logic [1:0] el;
        logic [1:0] g;
        logic       ev;
        cyc++;
        if (rst) begin
            chk("rst_req_ready", req_ready, 2'b00);
            chk("rst_rsp_valid", rsp_valid, 2'b00);
            busy[0] = 1'b0;
            busy[1] = 1'b0;
            last_g  = 1;
        end else begin
            el[0] = req_valid[0] && !busy[0];
            el[1] = req_valid[1] && !busy[1];
            if (el == 2'b11) g = (last_g == 1) ? 2'b01 : 2'b10;
            else             g = el;
            chk("req_ready", req_ready, g);
            for (int p = 0; p < 2; p++) begin
                ev = busy[p] && (cyc >= acc_cyc[p] + 2);
                chk($sformatf("rsp_valid[%0d]", p), rsp_valid[p], ev);
                if (ev && rsp_valid[p]) begin
                    chk($sformatf("rsp_result[%0d]", p), rsp_result[p], exp_res[p]);
                    chk($sformatf("rsp_zero[%0d]", p), rsp_zero[p], exp_res[p] == 32'd0);
                    chk($sformatf("rsp_illegal[%0d]", p), rsp_illegal[p], exp_ill[p]);
                    chk($sformatf("rsp_tag[%0d]", p), rsp_tag[p], exp_tag[p]);
                end
                if (ev && rsp_ready[p]) busy[p] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (g[p]) begin
                    busy[p]    = 1'b1;
                    acc_cyc[p] = cyc;
                    ref_alu(req_op[p], req_a[p], req_b[p], exp_res[p], exp_ill[p]);
                    exp_tag[p] = req_tag[p];
                    last_g     = p;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00;
        for (int p = 0; p < 2; p++) begin
            req_a[p] = '0; req_b[p] = '0; req_op[p] = '0; req_tag[p] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Present a request on port p and hold it until accepted.
    task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
        bit got;
        step();
        req_op[p] = op; req_a[p] = a; req_b[p] = b; req_tag[p] = tag;
        req_valid[p] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[p]) got = 1'b1;
        end
        if (!got) chk($sformatf("issue_timeout[%0d]", p), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    // Wait at negedges for a response on port p; returns the count of negedges.
    task automatic wait_rsp(input int p, output int waited);
        waited = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid[p]) begin
                waited = i;
                break;
            end
        end
        if (waited == 0) chk($sformatf("rsp_timeout[%0d]", p), 1'b0, 1'b1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    vec_t vt [10];
    bit   gq [$];

    initial begin
        int w;
        int p1_cnt;
        logic [31:0] specials [6];

        rst = 1'b1;
        rsp_ready = 2'b11;
        idle_inputs();
        step();
        step();
        chk("rst_result0", rsp_result[0], 32'd0);
        chk("rst_tag0", rsp_tag[0], 4'd0);
        chk("rst_zero", rsp_zero, 2'b00);
        chk("rst_illegal", rsp_illegal, 2'b00);
        rst = 1'b0;

        // ---- table-driven single operations on port 0 ----
        vt[0] = '{OP_ADD,  32'd5,          32'd7,          4'd3, 32'd12,         1'b0, 1'b0};
        vt[1] = '{OP_SUB,  32'd10,         32'd10,         4'd1, 32'd0,          1'b1, 1'b0};
        vt[2] = '{OP_ADD,  32'hFFFF_FFFF,  32'd1,          4'd2, 32'd0,          1'b1, 1'b0};
        vt[3] = '{OP_SLTU, 32'h8000_0000,  32'd1,          4'd4, 32'd0,          1'b1, 1'b0};
        vt[4] = '{OP_SLT,  32'h8000_0000,  32'd1,          4'd5, 32'd1,          1'b0, 1'b0};
        vt[5] = '{OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  4'd6, 32'hF000_F000,  1'b0, 1'b0};
        vt[6] = '{OP_XOR,  32'hAAAA_5555,  32'hFFFF_0000,  4'd7, 32'h5555_5555,  1'b0, 1'b0};
        vt[7] = '{OP_OR,   32'h0000_0F00,  32'h0000_000F,  4'd8, 32'h0000_0F0F,  1'b0, 1'b0};
        vt[8] = '{4'hF,    32'd1234,       32'd5678,       4'd9, 32'd0,          1'b1, 1'b1};
        vt[9] = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,          4'hA, 32'd1,          1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            issue(0, vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
            wait_rsp(0, w);
            chk($sformatf("vec%0d_latency", i), w, 2);
            chk($sformatf("vec%0d_result", i), rsp_result[0], vt[i].res);
            chk($sformatf("vec%0d_zero", i), rsp_zero[0], vt[i].zero);
            chk($sformatf("vec%0d_illegal", i), rsp_illegal[0], vt[i].ill);
            chk($sformatf("vec%0d_tag", i), rsp_tag[0], vt[i].tag);
            chk($sformatf("vec%0d_p1_quiet", i), rsp_valid[1], 1'b0);
        end

        // ---- both ports always valid: round-robin grants alternate ----
        step();
        do_reset();
        req_op[0] = OP_SUB; req_a[0] = 32'd10;         req_b[0] = 32'd10; req_tag[0] = 4'd1;
        req_op[1] = OP_SLT; req_a[1] = 32'hFFFF_FFFF;  req_b[1] = 32'd1;  req_tag[1] = 4'd2;
        req_valid = 2'b11;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) gq.push_back(req_ready[1]);
            if (rsp_valid[0]) chk("alt_p0_zero", {rsp_result[0], 31'd0, rsp_zero[0]}, 64'd1);
            if (rsp_valid[1]) chk("alt_p1_result", rsp_result[1], 32'd1);
        end
        step();
        req_valid = 2'b00;
        chk("alt_count_ge4", gq.size() >= 4, 1'b1);
        if (gq.size() > 0) chk("alt_first_port0", gq[0], 1'b0);
        for (int i = 1; i < gq.size(); i++) chk($sformatf("alt_grant%0d", i), gq[i], !gq[i-1]);
        repeat (4) step();

        // ---- tie after a port-0 grant: RR picks port 1, fixed picks port 0 ----
        do_reset();
        req_op[0] = OP_ADD; req_a[0] = 32'd1; req_b[0] = 32'd2; req_tag[0] = 4'd1;
        req_op[1] = OP_ADD; req_a[1] = 32'd3; req_b[1] = 32'd4; req_tag[1] = 4'd2;
        req_valid = 2'b01;
        @(negedge clk);
        chk("prio_solo_rr", req_ready, 2'b01);
        chk("prio_solo_fp", fp_req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        repeat (4) step();
        req_valid = 2'b11;
        @(negedge clk);
        chk("prio_tie_rr", req_ready, 2'b10);
        chk("prio_tie_fp", fp_req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("prio_fp_rsp_valid0", fp_rsp_valid[0], 1'b1);
        chk("prio_fp_result0", fp_rsp_result[0], 32'd3);
        chk("prio_fp_tag0", fp_rsp_tag[0], 4'd1);
        chk("prio_fp_flags0", {fp_rsp_zero[0], fp_rsp_illegal[0]}, 2'b00);
        repeat (4) step();

        // ---- backpressure on port 0 while port 1 keeps working ----
        do_reset();
        rsp_ready = 2'b10;
        issue(0, OP_ADD, 32'd100, 32'd23, 4'd5);
        wait_rsp(0, w);
        p1_cnt = 0;
        req_op[1] = OP_XOR; req_a[1] = 32'h0F0F_0F0F; req_b[1] = 32'h00FF_00FF; req_tag[1] = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            req_op[0] = OP_ADD; req_a[0] = $urandom; req_b[0] = 32'd1; req_tag[0] = 4'd6;
            req_valid = 2'b11;
            @(negedge clk);
            chk("bp_ready0", req_ready[0], 1'b0);
            chk("bp_valid0", rsp_valid[0], 1'b1);
            chk("bp_result0", rsp_result[0], 32'd123);
            chk("bp_tag0", rsp_tag[0], 4'd5);
            if (req_ready[1]) p1_cnt++;
        end
        chk("bp_p1_serviced", p1_cnt >= 1, 1'b1);
        step();
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        req_op[0] = OP_ADD; req_a[0] = 32'd2; req_b[0] = 32'd3; req_tag[0] = 4'd7;
        @(negedge clk);
        chk("bp_drain_cycle_ready0", req_ready[0], 1'b0);
        step();
        @(negedge clk);
        chk("bp_after_drain_ready0", req_ready[0], 1'b1);
        step();
        req_valid = 2'b00;
        repeat (4) step();

        // ---- reset while an op is in exec and a response is pending ----
        rsp_ready = 2'b00;
        issue(1, OP_ADD, 32'd1, 32'd2, 4'd4);
        wait_rsp(1, w);
        issue(0, OP_SUB, 32'd9, 32'd4, 4'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", rsp_valid, 2'b00);
        chk("mid_rst_ready", req_ready, 2'b00);
        chk("mid_rst_result", {rsp_result[0], rsp_result[1]}, 64'd0);
        chk("mid_rst_tag", {rsp_tag[0], rsp_tag[1]}, 8'd0);
        chk("mid_rst_flags", {rsp_zero, rsp_illegal}, 4'd0);
        step();
        rst = 1'b0;
        rsp_ready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", rsp_valid, 2'b00);
        end
        issue(0, OP_ADD, 32'd5, 32'd7, 4'd3);
        wait_rsp(0, w);
        chk("post_rst_latency", w, 2);
        chk("post_rst_result", rsp_result[0], 32'd12);

        // ---- randomized traffic against the reference model ----
        specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'd1;         specials[5] = 32'd0;
        for (int i = 0; i < 400; i++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                req_valid[p] = ($urandom_range(0, 2) != 0);
                req_op[p]    = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 7));
                req_a[p]     = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
                req_b[p]     = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
                req_tag[p]   = 4'($urandom);
                rsp_ready[p] = ($urandom_range(0, 3) != 0);
            end
        end
        step();
        idle_inputs();
        rsp_ready = 2'b11;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
